uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one UART transmitter between `NREQ` byte producers. Each requester offers bytes over a valid/ready interface. Requesters are granted in round-robin order, and a grant is held for a whole packet (until a byte marked `last`). The block sits between the producers and the transmitter. It drives the transmitter's active-low start strobe and byte input, and uses the transmitter's idle flag to sequence bytes.

## Interface
- `NREQ`, 4 — number of requesters, 2..8.
- `HOLD_TIMEOUT`, 16'd0 — clock cycles a locked owner may stall between packet bytes before the lock is dropped; 0 = never.

- `clk`  in  1  — single clock.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `req_valid`  in  NREQ  — requester i has a byte on its slice.
- `req_data`  in  8*NREQ  — byte of requester i at `[8*i+7:8*i]`.
- `req_last`  in  NREQ  — byte of requester i ends its packet.
- `req_ready`  out  NREQ  — one-hot; the byte is taken on this cycle.
- `tx_data`  out  8  — byte presented to the transmitter.
- `tx_start_n`  out  1  — start strobe, active-low, one cycle.
- `tx_idle`  in  1  — transmitter idle (1) / sending (0).
- `grant_id`  out  clog2(NREQ)  — current or last owner.
- `busy`  out  1  — 1 from capture of a packet's first byte until the packet is released.
- `hold_tmo`  out  1  — one-cycle pulse when a lock is dropped by timeout.

## Operation
- State machine: IDLE, START, WAIT_ACK, WAIT_DONE, HOLD.
- IDLE:
  - Round-robin search over `req_valid`, starting at `rr_ptr`.
  - Winner w: `req_ready[w]`=1 in the same cycle (combinational from state and valid).
  - On the edge: `tx_data`<=byte, `last_q`<=`req_last[w]`, `grant_id`<=w, `rr_ptr`<=w+1 mod NREQ, `busy`<=1, state -> START.
- START:
  - `tx_start_n`=0 only while `tx_idle`=1; then -> WAIT_ACK.
  - While `tx_idle`=0, `tx_start_n`=1 and the block stays in START.
- WAIT_ACK: `tx_start_n`=1; wait for `tx_idle`=0, then -> WAIT_DONE.
- WAIT_DONE: wait for `tx_idle`=1.
  - `last_q`=1: -> IDLE, `busy`<=0.
  - `last_q`=0: -> HOLD, hold counter cleared.
- HOLD: only requester `grant_id` is considered; other valids are ignored.
  - Owner valid: `req_ready[grant_id]`=1, capture as in IDLE (`rr_ptr` unchanged), -> START.
  - Otherwise the counter increments.
  - If `HOLD_TIMEOUT`≠0 and the counter reaches `HOLD_TIMEOUT`-1: `hold_tmo`=1 for one cycle, `busy`<=0, -> IDLE.
- `req_ready` is never asserted outside IDLE/HOLD.
- Requesters hold `req_data`/`req_last` stable while `req_valid` is high until ready.
- `tx_data` is constant from capture until the next capture.
- Hold counter is 16 bits and saturates; it does not wrap.

## Timing
- Reset values: `req_ready`=0, `tx_start_n`=1, `tx_data`=8'h00, `grant_id`=0, `busy`=0, `hold_tmo`=0. Internal: `rr_ptr`=0, state IDLE.
- Reset mid-frame: all outputs return to reset values immediately.
  - The transmitter may still be sending; START then waits for `tx_idle`=1 before strobing.
  - No byte is lost or duplicated other than the aborted one.
- Latency with `tx_idle`=1:
  - Valid in IDLE at cycle 0 → ready at cycle 0.
  - `tx_start_n` low at cycle 1.
  - `tx_idle` falls at cycle 2 and is seen in WAIT_ACK.
- Inter-byte overhead within a packet: 2 cycles after `tx_idle` rises (WAIT_DONE→HOLD→capture), then START.
- Simultaneous valids in IDLE: the lowest index at or after `rr_ptr` wins.
- A single-byte packet (`last`=1 on the first byte) releases after one frame.
- `req_last` is ignored except on captured bytes.

## Test plan
- Reset: drive `rst_n`=0 with all valids high → all outputs at reset values; after release, requester 0 is granted first.
- Round-robin: NREQ=4, all four valid with single-byte packets 8'hA0..8'hA3 → the TX model receives A0,A1,A2,A3, then A0 again; exactly one `tx_start_n` low pulse per byte.
- Packet lock: requester 2 sends 3 bytes 8'h11,8'h22,8'h33 (`last` on 8'h33) while requester 1 is valid → 11,22,33 are sent before requester 1's byte; `busy` stays high across the packet.
- Hold timeout: `HOLD_TIMEOUT`=8, owner stalls after the first non-last byte → `hold_tmo` pulses 8 cycles after entering HOLD; next grant goes to another valid requester.
- Busy transmitter: keep `tx_idle`=0 for 20 cycles after a capture → `tx_start_n` stays 1 until `tx_idle` rises, then pulses low for exactly one cycle.
- Reset mid-frame: assert `rst_n`=0 during WAIT_DONE → outputs reset; a fresh request afterwards is sent correctly once `tx_idle`=1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NREQ byte producers.
// Requesters win in round-robin order. The winner keeps the transmitter for a
// whole packet, which ends at a byte marked last. Between packet bytes the
// owner may stall; an optional timeout drops the lock.
//
// Handshake: req_valid[i] means requester i holds a stable byte on its slice
// of req_data and req_last. The byte is consumed on a rising edge where both
// req_valid[i] and req_ready[i] are high. req_ready is one-hot, is only ever
// asserted in IDLE or HOLD, and is driven combinationally from state and
// req_valid.
module uart_tx_arbiter #(
    parameter int          NREQ         = 4,
    parameter logic [15:0] HOLD_TIMEOUT = 16'd0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [8*NREQ-1:0]         req_data,
    input  logic [NREQ-1:0]           req_last,
    output logic [NREQ-1:0]           req_ready,
    output logic [7:0]                tx_data,
    output logic                      tx_start_n,
    input  logic                      tx_idle,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy,
    output logic                      hold_tmo,
    output logic [2:0]                dbg_state
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_HOLD      = 3'd4
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [IW-1:0]   rr_ptr;
    logic            last_q;
    logic [15:0]     hold_cnt;

    logic            found;
    logic [IW-1:0]   win;
    logic [IW-1:0]   win_next;
    logic            capture;
    logic [IW-1:0]   cap_id;
    logic            pkt_done;
    logic            cnt_clr;
    logic            cnt_inc;

    assign dbg_state = state;

    // Round-robin search: first valid requester at or after rr_ptr.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            int idx;
            idx = int'(rr_ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx[IW-1:0];
            end
        end
    end

    assign win_next = (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);

    // Next-state and outputs. The hold counter is cleared when HOLD is
    // entered and counts owner-stall cycles. Ready is masked during reset
    // so no byte is acknowledged while the block is held in reset.
    always_comb begin
        state_d    = state;
        req_ready  = '0;
        tx_start_n = 1'b1;
        hold_tmo   = 1'b0;
        capture    = 1'b0;
        cap_id     = win;
        pkt_done   = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            S_IDLE: begin
                if (rst_n && found) begin
                    req_ready[win] = 1'b1;
                    capture        = 1'b1;
                    cap_id         = win;
                    state_d        = S_START;
                end
            end
            S_START: begin
                if (tx_idle) begin
                    tx_start_n = 1'b0;
                    state_d    = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (!tx_idle) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (tx_idle) begin
                    if (last_q) begin
                        pkt_done = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        cnt_clr = 1'b1;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (rst_n && req_valid[grant_id]) begin
                    req_ready[grant_id] = 1'b1;
                    capture             = 1'b1;
                    cap_id              = grant_id;
                    state_d             = S_START;
                end else if ((HOLD_TIMEOUT != 16'd0) &&
                             (hold_cnt == HOLD_TIMEOUT - 16'd1)) begin
                    hold_tmo = 1'b1;
                    pkt_done = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    // Byte capture, ownership and round-robin pointer (advanced only on a
    // fresh grant from IDLE, never on a continuation byte from HOLD).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data  <= 8'h00;
            last_q   <= 1'b0;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else if (capture) begin
            tx_data  <= req_data[int'(cap_id)*8 +: 8];
            last_q   <= req_last[cap_id];
            grant_id <= cap_id;
            if (state == S_IDLE) rr_ptr <= win_next;
        end
    end

    // Busy spans from first-byte capture until the packet is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        busy <= 1'b0;
        else if (capture)  busy <= 1'b1;
        else if (pkt_done) busy <= 1'b0;
    end

    // Saturating hold counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         hold_cnt <= 16'd0;
        else if (cnt_clr)                   hold_cnt <= 16'd0;
        else if (cnt_inc && hold_cnt != '1) hold_cnt <= hold_cnt + 16'd1;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte queues, a cycle-based UART
// transmitter model, and a scoreboard of expected transmitted bytes.
module tb_uart_tx_arbiter;

    localparam int          NREQ  = 4;
    localparam int          FRAME = 10;
    localparam logic [15:0] HTO   = 16'd8;
    localparam logic [2:0]  ST_IDLE      = 3'd0;
    localparam logic [2:0]  ST_START     = 3'd1;
    localparam logic [2:0]  ST_WAIT_DONE = 3'd3;
    localparam logic [2:0]  ST_HOLD      = 3'd4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid = '0;
    logic [8*NREQ-1:0]   req_data  = '0;
    logic [NREQ-1:0]     req_last  = '0;
    logic [NREQ-1:0]     req_ready;
    logic [7:0]          tx_data;
    logic                tx_start_n;
    logic                tx_idle;
    logic [1:0]          grant_id;
    logic                busy;
    logic                hold_tmo;
    logic [2:0]          dbg_state;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    logic [8:0]      pbuf[NREQ][16];
    int              phead[NREQ];
    int              ptail[NREQ];
    logic [NREQ-1:0] drv_hs;

    int   tx_cnt = 0;
    logic tx_stall = 1'b0;
    int   start_low_cnt = 0;
    int   start_busy_cnt = 0;
    int   cyc = 0;

    uart_tx_arbiter #(.NREQ(NREQ), .HOLD_TIMEOUT(HTO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_data    (tx_data),
        .tx_start_n (tx_start_n),
        .tx_idle    (tx_idle),
        .grant_id   (grant_id),
        .busy       (busy),
        .hold_tmo   (hold_tmo),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- transmitter model ----------------
    assign tx_idle = (tx_cnt == 0) && !tx_stall;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!tx_start_n) start_low_cnt <= start_low_cnt + 1;
        if (!tx_start_n && !tx_idle) start_busy_cnt <= start_busy_cnt + 1;
        if (!tx_start_n && tx_idle) begin
            rx_q.push_back(tx_data);
            tx_cnt <= FRAME;
        end else if (tx_cnt != 0) begin
            tx_cnt <= tx_cnt - 1;
        end
    end

    // ---------------- requester driver ----------------
    always @(posedge clk) begin
        drv_hs = req_valid & req_ready;
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (drv_hs[i]) phead[i] = phead[i] + 1;
            if (phead[i] != ptail[i]) begin
                req_valid[i]         = 1'b1;
                req_data[8*i +: 8]   = pbuf[i][phead[i] & 15][7:0];
                req_last[i]          = pbuf[i][phead[i] & 15][8];
            end else begin
                req_valid[i]         = 1'b0;
                req_data[8*i +: 8]   = 8'h00;
                req_last[i]          = 1'b0;
            end
        end
    end

    task automatic push_byte(input int id, input logic [7:0] data, input logic last);
        pbuf[id][ptail[id] & 15] = {last, data};
        ptail[id] = ptail[id] + 1;
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < NREQ; i++)
            if (phead[i] != ptail[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_rx(input int n, input int budget, output bit ok);
        ok = 1'b0;
        repeat (budget) begin
            @(negedge clk);
            if (rx_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_quiet(output bit ok);
        ok = 1'b0;
        repeat (400) begin
            @(negedge clk);
            if (!busy && dbg_state == ST_IDLE && tx_idle && queues_empty()) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) push_byte(i, 8'hA0 + 8'(i), 1'b1);
        push_byte(0, 8'hA0, 1'b1);
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b, required 0000", req_ready); end
        checks++; if (tx_start_n !== 1'b1) begin errors++; $display("FAIL reset_start_n: got %b, required 1", tx_start_n); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h, required 00", tx_data); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d, required 0", grant_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        checks++; if (hold_tmo !== 1'b0) begin errors++; $display("FAIL reset_hold_tmo: got %b, required 0", hold_tmo); end
        exp_q.push_back(8'hA0); exp_q.push_back(8'hA1);
        exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
        exp_q.push_back(8'hA0);
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL first_grant_ready: got %b, required 0001", req_ready); end
        @(negedge clk);
        checks++; if (tx_data !== 8'hA0 || busy !== 1'b1) begin errors++; $display("FAIL first_capture: got data %h busy %b, required A0 1", tx_data, busy); end
    endtask

    task automatic test_round_robin();
        bit ok;
        wait_rx(5, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_wait: got %0d bytes, required 5", rx_q.size()); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (rx_q.size() == 0 || exp_q.size() == 0) begin
                errors++; $display("FAIL rr_byte%0d: got no byte, required scoreboard entry", k);
            end else begin
                logic [7:0] got, want;
                got = rx_q.pop_front(); want = exp_q.pop_front();
                if (got !== want) begin errors++; $display("FAIL rr_byte%0d: got %h, required %h", k, got, want); end
            end
        end
        checks++; if (start_low_cnt !== 5) begin errors++; $display("FAIL rr_strobes: got %0d, required 5", start_low_cnt); end
    endtask

    task automatic test_packet_lock();
        bit ok;
        int base, busy_drop;
        wait_quiet(ok);
        checks++; if (!ok) begin errors++; $display("FAIL lock_quiet: got busy, required idle"); end
        base = start_low_cnt;
        push_byte(2, 8'h11, 1'b0); push_byte(2, 8'h22, 1'b0); push_byte(2, 8'h33, 1'b1);
        ok = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (busy && grant_id == 2'd2) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL lock_grant2: got grant %0d, required 2", grant_id); end
        push_byte(1, 8'h55, 1'b1);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h55);
        busy_drop = 0;
        repeat (300) begin
            @(negedge clk);
            if (!busy) busy_drop++;
            if (rx_q.size() >= 3) break;
        end
        checks++; if (busy_drop !== 0) begin errors++; $display("FAIL lock_busy: got %0d low cycles, required 0", busy_drop); end
        wait_rx(4, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL lock_wait: got %0d bytes, required 4", rx_q.size()); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rx_q.size() == 0 || exp_q.size() == 0) begin
                errors++; $display("FAIL lock_byte%0d: got no byte, required scoreboard entry", k);
            end else begin
                logic [7:0] got, want;
                got = rx_q.pop_front(); want = exp_q.pop_front();
                if (got !== want) begin errors++; $display("FAIL lock_byte%0d: got %h, required %h", k, got, want); end
            end
        end
        checks++; if (start_low_cnt - base !== 4) begin errors++; $display("FAIL lock_strobes: got %0d, required 4", start_low_cnt - base); end
    endtask

    task automatic test_hold_timeout();
        bit ok;
        int hold_enter, tmo_cyc, tmo_pulses;
        wait_quiet(ok);
        checks++; if (!ok) begin errors++; $display("FAIL tmo_quiet: got busy, required idle"); end
        // rr_ptr is 2 here, so requester 3 wins over requester 0.
        push_byte(3, 8'h77, 1'b0);
        push_byte(0, 8'h88, 1'b1);
        exp_q.push_back(8'h77); exp_q.push_back(8'h88);
        hold_enter = -1; tmo_cyc = -1000; tmo_pulses = 0;
        repeat (400) begin
            @(negedge clk);
            if (dbg_state == ST_HOLD && hold_enter < 0) hold_enter = cyc;
            if (hold_tmo) begin tmo_pulses++; tmo_cyc = cyc; end
            if (rx_q.size() >= 2) break;
        end
        checks++; if (tmo_pulses !== 1) begin errors++; $display("FAIL tmo_pulses: got %0d, required 1", tmo_pulses); end
        // Pulse lands on the 8th cycle spent in HOLD (entry cycle counts as 1st).
        checks++; if (tmo_cyc - hold_enter !== int'(HTO) - 1) begin errors++; $display("FAIL tmo_delay: got %0d, required %0d", tmo_cyc - hold_enter, int'(HTO) - 1); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL tmo_next_grant: got %0d, required 0", grant_id); end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rx_q.size() == 0 || exp_q.size() == 0) begin
                errors++; $display("FAIL tmo_byte%0d: got no byte, required scoreboard entry", k);
            end else begin
                logic [7:0] got, want;
                got = rx_q.pop_front(); want = exp_q.pop_front();
                if (got !== want) begin errors++; $display("FAIL tmo_byte%0d: got %h, required %h", k, got, want); end
            end
        end
    endtask

    task automatic test_busy_tx();
        bit ok;
        int base, bad;
        wait_quiet(ok);
        checks++; if (!ok) begin errors++; $display("FAIL btx_quiet: got busy, required idle"); end
        tx_stall = 1'b1;
        base = start_low_cnt;
        push_byte(1, 8'h99, 1'b1);
        exp_q.push_back(8'h99);
        ok = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (busy) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL btx_capture: got busy %b, required 1", busy); end
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_start_n !== 1'b1 || dbg_state !== ST_START) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL btx_held: got %0d bad cycles, required 0", bad); end
        tx_stall = 1'b0;
        wait_rx(1, 50, ok);
        repeat (4) @(negedge clk);
        checks++; if (start_low_cnt - base !== 1) begin errors++; $display("FAIL btx_pulse: got %0d low cycles, required 1", start_low_cnt - base); end
        checks++;
        if (rx_q.size() == 0 || exp_q.size() == 0) begin
            errors++; $display("FAIL btx_byte: got no byte, required 99");
        end else begin
            logic [7:0] got, want;
            got = rx_q.pop_front(); want = exp_q.pop_front();
            if (got !== want) begin errors++; $display("FAIL btx_byte: got %h, required %h", got, want); end
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int busy_base;
        wait_quiet(ok);
        checks++; if (!ok) begin errors++; $display("FAIL mrst_quiet: got busy, required idle"); end
        push_byte(2, 8'hC1, 1'b1);
        exp_q.push_back(8'hC1);
        ok = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (dbg_state == ST_WAIT_DONE) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL mrst_wait_done: got state %0d, required 3", dbg_state); end
        rst_n = 1'b0;
        #1;
        checks++; if (tx_data !== 8'h00 || busy !== 1'b0 || grant_id !== 2'd0) begin errors++; $display("FAIL mrst_regs: got data %h busy %b grant %0d, required 00 0 0", tx_data, busy, grant_id); end
        checks++; if (tx_start_n !== 1'b1 || req_ready !== 4'b0000 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL mrst_comb: got start_n %b ready %b state %0d, required 1 0000 0", tx_start_n, req_ready, dbg_state); end
        @(negedge clk);
        rst_n = 1'b1;
        busy_base = start_busy_cnt;
        push_byte(3, 8'hD2, 1'b1);
        exp_q.push_back(8'hD2);
        wait_rx(2, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mrst_wait: got %0d bytes, required 2", rx_q.size()); end
        checks++; if (start_busy_cnt !== busy_base) begin errors++; $display("FAIL mrst_strobe_busy: got %0d, required %0d", start_busy_cnt, busy_base); end
        checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL mrst_grant: got %0d, required 3", grant_id); end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rx_q.size() == 0 || exp_q.size() == 0) begin
                errors++; $display("FAIL mrst_byte%0d: got no byte, required scoreboard entry", k);
            end else begin
                logic [7:0] got, want;
                got = rx_q.pop_front(); want = exp_q.pop_front();
                if (got !== want) begin errors++; $display("FAIL mrst_byte%0d: got %h, required %h", k, got, want); end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < NREQ; i++) begin
            phead[i] = 0;
            ptail[i] = 0;
        end
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_hold_timeout();
        test_busy_tx();
        test_reset_midframe();
        repeat (20) @(negedge clk);
        checks++; if (rx_q.size() !== 0 || exp_q.size() !== 0) begin errors++; $display("FAIL leftover: got rx %0d exp %0d, required 0 0", rx_q.size(), exp_q.size()); end
        checks++; if (start_busy_cnt !== 0) begin errors++; $display("FAIL strobe_while_busy: got %0d, required 0", start_busy_cnt); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
